cnt_seq_ctrl: RTL and testbench
===============================

// Module: cnt_seq_ctrl
// PURPOSE
//   Register-and-control stage of the increment/select counter datapath.
//   - Holds count register R; drives the select decision (load vs R+1) and consumes the selected next value.
//   - Start handshake accepts a load value and a limit; the block counts up from the load value to the limit, then pulses done.
//   - Downstream logic sees the running count and the status flags.
// PARAMETERS
//   WIDTH   8   bit width of count register, load value and limit
// PORTS
//   clk          in   1      single clock; all state updates on rising edge
//   rst          in   1      synchronous, active-high reset
//   start_valid  in   1      request to begin a count sequence
//   start_ready  out  1      block can accept a request (state IDLE)
//   load_val     in   WIDTH  start value, sampled on handshake
//   limit        in   WIDTH  terminal value, sampled on handshake
//   count_out    out  WIDTH  current contents of R
//   busy         out  1      high in LOAD, COUNT, DONE
//   done         out  1      one-cycle pulse, high only in DONE
//   pause        in   1      only present with CNT_PAUSE_EN
// BEHAVIOUR
//   Reset: on rst=1 at an edge -> state IDLE, R=0, limit_q=0.
//     Outputs after that edge: count_out=0, busy=0, done=0, start_ready=1.
//     rst overrides every other input, including mid-sequence; no done is emitted for an aborted sequence.
//   start_ready, busy and done are decoded from state only (no input-to-output combinational path).
//   Handshake: accept iff start_valid && start_ready at an edge.
//     On accept, load_val and limit are captured.
//     start_valid outside IDLE is ignored; the request is not queued.
//   FSM:
//     IDLE  -> LOAD on accept; R holds.
//     LOAD  -> COUNT; R <= load_val_q (select = load path).
//     COUNT -> if R == limit_q: go to DONE, R holds.
//              else: R <= R+1 (select = increment path), stay in COUNT.
//     DONE  -> IDLE; R holds the final value (== limit_q) until the next LOAD.
//   Arithmetic: R+1 is modulo 2^WIDTH. 8'hFF+1 = 8'h00 with no flag.
//     A limit below load_val counts through the wrap.
//   Timing (accept at edge k):
//     N = ((limit - load_val) mod 2^WIDTH) + 1 COUNT cycles.
//     count_out = load_val after edge k+1.
//     done high in the cycle after edge k+1+N.
//     IDLE (start_ready=1) after edge k+2+N.
//   load_val == limit: N=1, so done follows edge k+2.
// CONFIGURATION
//   CNT_PAUSE_EN defined:
//     Port pause exists.
//     pause=1 in COUNT: R and state hold, and the compare is not acted on.
//     pause is ignored in all other states.
//     Each paused cycle delays done by 1.
//   CNT_PAUSE_EN undefined: no pause port; COUNT never stalls.
// STRUCTURE
//   Package cnt_pkg:
//     - state enum cnt_state_t: IDLE=2'b00, LOAD=2'b01, COUNT=2'b10, DONE=2'b11.
//     - localparam CNT_WIDTH_DEF=8.
//   Sub-module cnt_seq_fsm:
//     - inputs: state register, accept, eq compare, pause.
//     - outputs: next state, sel_load, inc_en, start_ready, busy, done.
//   Top holds R, load_val_q, limit_q, the incrementer and the 2:1 select.
// TESTING
//   1. Accept load_val=8'h05, limit=8'h08 at edge k
//      -> count_out 05,06,07,08 after edges k+1..k+4; done=1 only after edge k+5; start_ready=1 after k+6.
//   2. load_val=limit=8'h3C
//      -> count_out=3C after edge k+1; done pulse after edge k+2; R stays 3C.
//   3. Wrap: load_val=8'hFE, limit=8'h01
//      -> count_out FE,FF,00,01; done after edge k+5; no other flag toggles.
//   4. Hold start_valid=1 during COUNT with new values
//      -> ignored, start_ready=0.
//      After return to IDLE, a new request is accepted with the new values.
//   5. Assert rst for one edge mid-COUNT (R=8'h06)
//      -> next cycle count_out=0, busy=0, done=0, start_ready=1; done never pulses.
//   6. With CNT_PAUSE_EN, test 1 with pause=1 for 2 cycles while R=8'h06
//      -> R holds 06 for those cycles; done delayed to after edge k+7.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared types for the count sequencer: FSM state encoding and default width.
package cnt_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    COUNT = 2'b10,
    DONE  = 2'b11
  } cnt_state_t;

endpackage

// File: rtl/cnt_seq_fsm.sv
// Next-state and control decode for the count sequencer; state register lives in the top.
module cnt_seq_fsm
  import cnt_pkg::*;
(
  input  cnt_state_t state,
  input  logic       accept,
  input  logic       eq,
  input  logic       pause,
  output cnt_state_t next_state,
  output logic       sel_load,
  output logic       inc_en,
  output logic       start_ready_c,
  output logic       busy_c,
  output logic       done_c
);

  always_comb begin
    next_state = state;
    sel_load   = 1'b0;
    inc_en     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) next_state = LOAD;
      end
      LOAD: begin
        sel_load   = 1'b1;
        next_state = COUNT;
      end
      COUNT: begin
        // A paused cycle freezes both R and the terminal compare.
        if (!pause) begin
          if (eq) next_state = DONE;
          else    inc_en     = 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Status decoded from the upcoming state so the top can register it alongside the state.
  assign start_ready_c = (next_state == IDLE);
  assign busy_c        = (next_state != IDLE);
  assign done_c        = (next_state == DONE);

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Count register and control: loads a start value, counts up (mod 2^WIDTH) to a limit, pulses done.
// Optional stall input enabled by defining CNT_PAUSE_EN.
module cnt_seq_ctrl
  import cnt_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             done
`ifdef CNT_PAUSE_EN
  ,
  input  logic             pause
`endif
);

  cnt_state_t       state_q;
  cnt_state_t       next_state;
  logic [WIDTH-1:0] load_val_q;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] count_nxt;
  logic             accept;
  logic             eq;
  logic             pause_int;
  logic             sel_load;
  logic             inc_en;
  logic             start_ready_c;
  logic             busy_c;
  logic             done_c;

`ifdef CNT_PAUSE_EN
  assign pause_int = pause;
`else
  assign pause_int = 1'b0;
`endif

  assign accept    = start_valid && start_ready;
  assign eq        = (count_out == limit_q);
  // 2:1 select between the captured load value and the wrapping incrementer.
  assign count_nxt = sel_load ? load_val_q : count_out + WIDTH'(1);

  cnt_seq_fsm u_fsm (
    .state         (state_q),
    .accept        (accept),
    .eq            (eq),
    .pause         (pause_int),
    .next_state    (next_state),
    .sel_load      (sel_load),
    .inc_en        (inc_en),
    .start_ready_c (start_ready_c),
    .busy_c        (busy_c),
    .done_c        (done_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      load_val_q  <= '0;
      limit_q     <= '0;
      count_out   <= '0;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= next_state;
      start_ready <= start_ready_c;
      busy        <= busy_c;
      done        <= done_c;
      if (accept) begin
        load_val_q <= load_val;
        limit_q    <= limit;
      end
      if (sel_load || inc_en) count_out <= count_nxt;
    end
  end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Bench for cnt_seq_ctrl: cycle-level sequence model plus directed vectors with literal expectations.
module tb_cnt_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] load_val;
  logic [7:0] limit;
  logic [7:0] count_out;
  logic       busy;
  logic       done;
  logic       pause;

  int tests_run    = 0;
  int tests_failed = 0;

  cnt_seq_ctrl #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .load_val    (load_val),
    .limit       (limit),
    .count_out   (count_out),
    .busy        (busy),
    .done        (done)
`ifdef CNT_PAUSE_EN
    ,
    .pause       (pause)
`endif
  );

  always #5 clk = ~clk;

  // Sequence model: e = edges since accept; N count cycles follow the load edge.
  logic       m_valid = 1'b0;
  logic       m_active;
  int         m_e;
  int         m_n;
  logic [7:0] m_r;
  logic [7:0] m_lv;
  logic [7:0] m_lim;
  logic       m_pause;

  always @(posedge clk) begin
`ifdef CNT_PAUSE_EN
    m_pause = pause;
`else
    m_pause = 1'b0;
`endif
    if (rst) begin
      m_active = 1'b0;
      m_r      = 8'h00;
      m_e      = 0;
      m_n      = 0;
      m_valid  = 1'b1;
    end else if (!m_active) begin
      if (start_valid) begin
        m_active = 1'b1;
        m_e      = 0;
        m_lv     = load_val;
        m_lim    = limit;
        m_n      = int'(8'(limit - load_val)) + 1;
      end
    end else if (m_e == 0) begin
      m_e = 1;
      m_r = m_lv;
    end else if (m_e <= m_n) begin
      if (!m_pause) begin
        m_e = m_e + 1;
        m_r = (m_e <= m_n) ? 8'(int'(m_lv) + m_e - 1) : m_lim;
      end
    end else begin
      m_active = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("mdl_count", 32'(count_out), 32'(m_r));
      chk("mdl_busy", 32'(busy), 32'(m_active));
      chk("mdl_done", 32'(done), 32'(m_active && (m_e == m_n + 1)));
      chk("mdl_ready", 32'(start_ready), 32'(!m_active));
    end
  end

  task automatic start_req(input logic [7:0] lv, input logic [7:0] lim);
    @(negedge clk);
    start_valid = 1'b1;
    load_val    = lv;
    limit       = lim;
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  task automatic wait_ready(input int max_cycles);
    int n = 0;
    while (!start_ready && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready_timeout", 32'(start_ready), 32'd1);
  endtask

  initial begin
    logic saw_done;
    clk         = 1'b0;
    rst         = 1'b1;
    start_valid = 1'b0;
    load_val    = 8'h00;
    limit       = 8'h00;
    pause       = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_count", 32'(count_out), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(start_ready), 32'd1);

    // Basic 05 -> 08
    start_req(8'h05, 8'h08);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_count", 32'(count_out), 32'(8'h05 + 8'(i)));
      chk("t1_nodone", 32'(done), 32'd0);
    end
    @(negedge clk);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_final", 32'(count_out), 32'h08);
    @(negedge clk);
    chk("t1_ready", 32'(start_ready), 32'd1);
    chk("t1_done_off", 32'(done), 32'd0);

    // load == limit
    start_req(8'h3C, 8'h3C);
    @(negedge clk);
    chk("t2_count", 32'(count_out), 32'h3C);
    chk("t2_nodone", 32'(done), 32'd0);
    @(negedge clk);
    chk("t2_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("t2_ready", 32'(start_ready), 32'd1);
    chk("t2_hold", 32'(count_out), 32'h3C);

    // Wrap FE -> 01
    start_req(8'hFE, 8'h01);
    begin
      logic [7:0] exp_w [4];
      exp_w[0] = 8'hFE; exp_w[1] = 8'hFF; exp_w[2] = 8'h00; exp_w[3] = 8'h01;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("t3_count", 32'(count_out), 32'(exp_w[i]));
        chk("t3_nodone", 32'(done), 32'd0);
      end
    end
    @(negedge clk);
    chk("t3_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("t3_ready", 32'(start_ready), 32'd1);

    // Request held during a sequence is ignored until IDLE
    start_req(8'h10, 8'h12);
    start_valid = 1'b1;
    load_val    = 8'hAA;
    limit       = 8'hAB;
    @(negedge clk);
    chk("t4_busy_ready", 32'(start_ready), 32'd0);
    chk("t4_count", 32'(count_out), 32'h10);
    @(negedge clk);
    chk("t4_ignored", 32'(count_out), 32'h11);
    wait_ready(20);
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    chk("t4_new_load", 32'(count_out), 32'hAA);
    wait_ready(20);

    // Reset mid-COUNT aborts without done
    start_req(8'h05, 8'h08);
    @(negedge clk);
    chk("t5_count5", 32'(count_out), 32'h05);
    @(negedge clk);
    chk("t5_count6", 32'(count_out), 32'h06);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_count", 32'(count_out), 32'h00);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_ready", 32'(start_ready), 32'd1);
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("t5_never_done", 32'(saw_done), 32'd0);

`ifdef CNT_PAUSE_EN
    // Two paused cycles at R=06 delay done to edge k+7
    start_req(8'h05, 8'h08);
    @(negedge clk);
    chk("t6_count5", 32'(count_out), 32'h05);
    @(negedge clk);
    chk("t6_count6", 32'(count_out), 32'h06);
    pause = 1'b1;
    @(negedge clk);
    chk("t6_hold1", 32'(count_out), 32'h06);
    @(negedge clk);
    chk("t6_hold2", 32'(count_out), 32'h06);
    pause = 1'b0;
    @(negedge clk);
    chk("t6_count7", 32'(count_out), 32'h07);
    @(negedge clk);
    chk("t6_count8", 32'(count_out), 32'h08);
    chk("t6_nodone", 32'(done), 32'd0);
    @(negedge clk);
    chk("t6_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("t6_ready", 32'(start_ready), 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
